// File: rtl/clk_div_pll.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pll
// Brief    : Multi-channel integer clock divider with glitch-free enables,
//            common phase-align sync and a re-qualifying lock indicator.
//            Every output is a register clocked by the reference clock.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_pll #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    i_ref_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic                    i_sync,
  output logic [NUM_CH-1:0]       o_clk,
  output logic [NUM_CH-1:0]       o_tick,
  output logic                    o_lock
);

  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  // Per-channel state
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  div_d [NUM_CH];

  // Sanitised divisor per channel and "latched a different divisor" flags
  logic [DIV_W-1:0]  div_san [NUM_CH];
  logic [NUM_CH-1:0] div_chg;

  // Lock qualification
  logic [LC_W-1:0]   lc_q, lc_d;
  logic              lock_q, lock_d;
  logic              restart;

  // Divide values 0 and 1 fold to 2: divide-by-1 cannot be produced glitch-free
  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_san
      assign div_san[g] = (i_div[g*DIV_W +: DIV_W] < DIV_W'(2)) ? DIV_W'(2)
                                                                : i_div[g*DIV_W +: DIV_W];
    end
  endgenerate

  // Next-state for each channel; divisor and enable are only honoured at a period boundary
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      run_d[c]   = run_q[c];
      cnt_d[c]   = cnt_q[c];
      div_d[c]   = div_q[c];
      clk_d[c]   = 1'b0;
      tick_d[c]  = 1'b0;
      div_chg[c] = 1'b0;
      if (i_sync) begin
        run_d[c]   = i_en[c];
        cnt_d[c]   = '0;
        div_d[c]   = div_san[c];
        clk_d[c]   = i_en[c];
        tick_d[c]  = i_en[c];
        div_chg[c] = (div_san[c] != div_q[c]);
      end else if (!run_q[c]) begin
        if (i_en[c]) begin
          run_d[c]   = 1'b1;
          cnt_d[c]   = '0;
          div_d[c]   = div_san[c];
          clk_d[c]   = 1'b1;
          tick_d[c]  = 1'b1;
          div_chg[c] = (div_san[c] != div_q[c]);
        end
      end else if (cnt_q[c] == (div_q[c] - DIV_W'(1))) begin
        cnt_d[c] = '0;
        if (i_en[c]) begin
          div_d[c]   = div_san[c];
          clk_d[c]   = 1'b1;
          tick_d[c]  = 1'b1;
          div_chg[c] = (div_san[c] != div_q[c]);
        end else begin
          run_d[c] = 1'b0;
        end
      end else begin
        cnt_d[c] = cnt_q[c] + DIV_W'(1);
        // High for the first floor(div/2) counts of the period
        clk_d[c] = (({1'b0, cnt_q[c]} + (DIV_W+1)'(1)) < ({1'b0, div_q[c]} >> 1));
      end
    end
  end

  // Lock counter restarts on sync or any real frequency change, otherwise saturates
  always_comb begin
    restart = i_sync | (|div_chg);
    lc_d    = lc_q;
    lock_d  = lock_q;
    if (restart) begin
      lc_d   = '0;
      lock_d = 1'b0;
    end else begin
      if (lc_q != LC_W'(LOCK_CYCLES)) begin
        lc_d = lc_q + LC_W'(1);
      end
      if (lc_q >= LC_W'(LOCK_CYCLES - 1)) begin
        lock_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset abandons any partial period
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      run_q  <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= '0;
      end
      lc_q   <= '0;
      lock_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        div_q[c] <= div_d[c];
      end
      lc_q   <= lc_d;
      lock_q <= lock_d;
    end
  end

  assign o_clk  = clk_q;
  assign o_tick = tick_q;
  assign o_lock = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_pll.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_pll
// Brief    : Directed plus randomised stimulus for clk_div_pll, compared every
//            cycle against a period/position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_pll;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 4;
  localparam int L      = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*DIV_W-1:0] div;
  logic                    sync;
  logic [NUM_CH-1:0]       o_clk;
  logic [NUM_CH-1:0]       o_tick;
  logic                    o_lock;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a position within a period of m_per cycles
  int m_run [NUM_CH];
  int m_pos [NUM_CH];
  int m_per [NUM_CH];
  int m_since;

  clk_div_pll #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(L)) dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_div     (div),
    .i_sync    (sync),
    .o_clk     (o_clk),
    .o_tick    (o_tick),
    .o_lock    (o_lock)
  );

  always #5 clk = ~clk;

  function automatic int san(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int slice(input int c);
    return int'(div[c*DIV_W +: DIV_W]);
  endfunction

  task automatic model_edge();
    bit restart;
    bit load;
    int n;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_run[c] = 0; m_pos[c] = 0; m_per[c] = 0;
      end
      m_since = 0;
    end else begin
      restart = sync;
      for (int c = 0; c < NUM_CH; c++) begin
        load = 1'b0;
        n = san(slice(c));
        if (sync) begin
          m_run[c] = en[c] ? 1 : 0; m_pos[c] = 0; load = 1'b1;
        end else if (m_run[c] == 0) begin
          if (en[c]) begin m_run[c] = 1; m_pos[c] = 0; load = 1'b1; end
        end else if (m_pos[c] == m_per[c] - 1) begin
          m_pos[c] = 0;
          if (en[c]) load = 1'b1;
          else m_run[c] = 0;
        end else begin
          m_pos[c]++;
        end
        if (load && n != m_per[c]) begin
          restart = 1'b1;
          m_per[c] = n;
        end
      end
      m_since = restart ? 0 : ((m_since < L) ? m_since + 1 : L);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One reference edge: advance the model, then compare all outputs 1ns later
  task automatic cyc();
    logic [NUM_CH-1:0] e_clk;
    logic [NUM_CH-1:0] e_tick;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      e_clk[c]  = (m_run[c] != 0) && (m_pos[c] < m_per[c] / 2);
      e_tick[c] = (m_run[c] != 0) && (m_pos[c] == 0);
    end
    chk("o_clk",  32'(o_clk),  32'(e_clk));
    chk("o_tick", 32'(o_tick), 32'(e_tick));
    chk("o_lock", 32'(o_lock), (m_since >= L) ? 32'd1 : 32'd0);
  endtask

  task automatic cycs(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_for(input int ch, input bit use_tick);
    int n = 0;
    while (!(use_tick ? o_tick[ch] : o_clk[ch]) && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $error("FAIL wait_ch%0d: observed=timeout expected=edge within 40 cycles", ch);
    end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; en = 2'b00; div = {4'd3, 4'd4};
    cycs(2);
    chk("rst_clk",  32'(o_clk),  32'd0);
    chk("rst_lock", 32'(o_lock), 32'd0);

    // Start both channels, then hold until lock
    rst = 1'b0; en = 2'b11;
    cyc();
    chk("start_clk",  32'(o_clk),  32'h3);
    chk("start_tick", 32'(o_tick), 32'h3);
    cycs(15);
    chk("lock_early", 32'(o_lock), 32'd0);
    cyc();
    chk("lock_rise",  32'(o_lock), 32'd1);
    cycs(4);

    // Divisor change on ch0 during a high phase
    wait_for(0, 1'b0);
    div = {4'd3, 4'd6};
    cycs(30);
    chk("relock", 32'(o_lock), 32'd1);

    // Disable ch1 right at its first high cycle, then re-enable
    wait_for(1, 1'b1);
    en = 2'b01;
    cycs(6);
    chk("dis_clk1", 32'(o_clk[1]), 32'd0);
    chk("dis_lock", 32'(o_lock),   32'd1);
    en = 2'b11;
    cyc();
    chk("reen_tick1", 32'(o_tick[1]), 32'd1);

    // Phase-align sync
    cycs(2);
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("sync_clk",  32'(o_clk),  32'h3);
    chk("sync_tick", 32'(o_tick), 32'h3);
    cycs(15);
    chk("sync_lock_low", 32'(o_lock), 32'd0);
    cyc();
    chk("sync_lock_up",  32'(o_lock), 32'd1);

    // Divisors 0 and 1 both behave as 2; changing between them is not a restart
    div = {4'd3, 4'd0};
    cycs(24);
    chk("div0_lock", 32'(o_lock), 32'd1);
    div = {4'd3, 4'd1};
    cycs(4);
    chk("div1_lock", 32'(o_lock), 32'd1);

    // Reset mid-high-phase
    div = {4'd3, 4'd4};
    cycs(8);
    wait_for(0, 1'b0);
    rst = 1'b1;
    cyc();
    chk("mrst_clk",  32'(o_clk),  32'd0);
    chk("mrst_tick", 32'(o_tick), 32'd0);
    chk("mrst_lock", 32'(o_lock), 32'd0);
    rst = 1'b0;
    cyc();
    chk("mrst_restart", 32'(o_clk), 32'h3);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      r    = int'($urandom_range(0, 99));
      rst  = (r < 2);
      sync = (r >= 2 && r < 5);
      if ($urandom_range(0, 7) == 0)  en  = 2'($urandom);
      if ($urandom_range(0, 15) == 0) div = 8'($urandom);
      cyc();
    end
    rst = 1'b0; sync = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
